fuzzy_pi_integrator: RTL and testbench
======================================

FUZZY_PI_INTEGRATOR -- requirements
Module: fuzzy_pi_integrator

Interface
REQ-001 Parameter N, default 16: data width; du, u, u_min and u_max are signed Q1.(N-1).
REQ-002 Parameter aN, default 4: integer bits (including sign) of k_gain, which is signed Q(aN).(N-aN).
REQ-003 clk  input  1  clock; all logic on posedge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 du_valid  input  1  one-cycle strobe from the fuzzy regulator rdy.
REQ-006 du  input  N  control increment from the fuzzy regulator out.
REQ-007 k_gain  input  N  integration gain.
REQ-008 u_min, u_max  input  N each  output clamp limits; u_min <= u_max is required of the driver.
REQ-009 clear  input  1  synchronous clear of the accumulator.
REQ-010 hold  input  1  freeze integration; samples are accepted but not accumulated.
REQ-011 u  output  N  integrated control output.
REQ-012 u_valid  output  1  one-cycle strobe when u is updated.
REQ-013 busy  output  1  high from the cycle after du_valid is accepted until u_valid.
REQ-014 sat_hi, sat_lo  output  1 each  the last update was clamped at u_max or u_min.
REQ-015 overrun  output  1  sticky; a du_valid arrived while busy.

Function
REQ-016 FSM states: IDLE, MUL, ACC; one-hot encoding.
REQ-017 IDLE: when du_valid=1, du and k_gain are registered, the iteration counter is set to 0, and the FSM goes to MUL.
REQ-018 MUL: signed serial shift-add, one du bit per cycle, LSB first; the MSB partial product is subtracted; exactly N cycles; then the FSM goes to ACC.
REQ-019 Product width is 2N signed; scaled = product >>> (N-aN), truncated (floor), with no rounding.
REQ-020 ACC: if hold=0, sum = acc + scaled in N+aN+2 bits; the clamped result is stored to acc and u; sat_hi and sat_lo are updated.
REQ-021 ACC with hold=1: acc and u are unchanged, sat_hi and sat_lo are unchanged, and u_valid is still pulsed.
REQ-022 Clamp rule: sum > u_max gives u = u_max and sat_hi=1; sum < u_min gives u = u_min and sat_lo=1; otherwise u = sum[N-1:0] and both flags are 0.
REQ-023 ACC lasts 1 cycle: u_valid=1 and busy=0 in the cycle after ACC, and the FSM returns to IDLE.
REQ-024 Latency: du_valid sampled at edge 0 gives u_valid high after edge N+2.
REQ-025 du_valid while the FSM is not in IDLE: the sample is dropped and overrun is set to 1.
REQ-026 du_valid in the same cycle as u_valid: the sample is accepted, because the FSM is already back in IDLE.
REQ-027 clear=1 in any state: acc, u, sat_hi, sat_lo and overrun go to 0 and the FSM goes to IDLE; no u_valid is produced.
REQ-028 clear has priority over du_valid in the same cycle; that du_valid is ignored.
REQ-029 u_min, u_max and hold are sampled only in ACC.
REQ-030 acc never leaves [u_min, u_max] after any update; this clamping is the anti-windup mechanism.

Reset
REQ-031 rst=1 drives: state=IDLE, acc=0, u=0, u_valid=0, busy=0, sat_hi=0, sat_lo=0, overrun=0, and clears the multiplier registers.
REQ-032 rst asserted during MUL aborts the operation; no u_valid is produced after release.
REQ-033 The first du_valid after reset release is accepted normally.

Structure
REQ-034 The shared package holds the FSM state constants and the fixed-point width constants (N, aN, accumulator width N+aN+2).
REQ-035 One sub-module, serial_mult_signed: start, a, b, busy, done, 2N-bit product.
REQ-036 The top level contains the FSM, the accumulator, the clamp and the flags.

Verification (N=16, aN=4, u_min=0x9000, u_max=0x7000)
REQ-037 Nominal: k_gain=0x1000 (1.0), du=0x4000, u=0 -> u=0x4000; u_valid exactly 18 cycles after du_valid; sat_hi=0, sat_lo=0.
REQ-038 Positive saturation: second du=0x4000 -> u=0x7000, sat_hi=1; then du=0xC000 (-0.5) -> u=0x3000, sat_hi=0.
REQ-039 Gain and negative clamp: k_gain=0x2000 (2.0), du=0xC000, from u=0 -> u=0x9000, sat_lo=1; acc stays 0x9000, with no windup on the next step.
REQ-040 Overrun: du_valid, then a second du_valid 5 cycles later -> overrun=1, a single u_valid, and u reflects the first sample only.
REQ-041 Hold and clear: hold=1 during ACC -> u_valid pulses and u is unchanged; clear=1 together with du_valid -> u=0, overrun=0, no u_valid.
REQ-042 Reset mid-MUL: rst asserted in cycle 8 of MUL -> all outputs 0; no u_valid within 20 cycles after release.

Source files
------------

// File: rtl/fuzzy_pi_integrator_pkg.sv
// Shared constants for the fuzzy PI integrator:
// fixed-point widths and one-hot FSM state codes.
package fuzzy_pi_integrator_pkg;

   localparam int FP_N    = 16;
   localparam int FP_AN   = 4;
   localparam int FP_ACCW = FP_N + FP_AN + 2;

   typedef enum logic [2:0] {
      S_IDLE = 3'b001,
      S_MUL  = 3'b010,
      S_ACC  = 3'b100
   } state_e;

endpackage

// File: rtl/fuzzy_pi_integrator_serial_mult_signed.sv
// Signed serial shift-add multiplier, one bit of a per cycle,
// LSB first; the sign bit's partial product is subtracted.
module serial_mult_signed #(
   parameter int N = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [N-1:0]     a,
   input  logic [N-1:0]     b,
   output logic             busy,
   output logic             done,
   output logic [2*N-1:0]   product
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;

   logic [N-1:0]   a_q;
   logic [2*N-1:0] mc_q;
   logic [2*N-1:0] prod_q;
   logic [CW-1:0]  cnt_q;
   logic           busy_q;
   logic           done_q;
   logic           last;

   assign last    = (cnt_q == CW'(N - 1));
   assign busy    = busy_q;
   assign done    = done_q;
   assign product = prod_q;

   // load operands on start, then one shift-add step per cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q    <= '0;
         mc_q   <= '0;
         prod_q <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (start) begin
            a_q    <= a;
            mc_q   <= {{N{b[N-1]}}, b};
            prod_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
         end else if (busy_q) begin
            if (a_q[0]) begin
               if (last) prod_q <= prod_q - mc_q;
               else      prod_q <= prod_q + mc_q;
            end
            mc_q  <= mc_q << 1;
            a_q   <= a_q >> 1;
            cnt_q <= cnt_q + CW'(1);
            if (last) begin
               busy_q <= 1'b0;
               done_q <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/fuzzy_pi_integrator.sv
// Integrates fuzzy-regulator increments scaled by a gain,
// clamping the accumulator to [u_min, u_max] (anti-windup).
module fuzzy_pi_integrator
   import fuzzy_pi_integrator_pkg::*;
#(
   parameter int N  = FP_N,
   parameter int aN = FP_AN
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         du_valid,
   input  logic [N-1:0] du,
   input  logic [N-1:0] k_gain,
   input  logic [N-1:0] u_min,
   input  logic [N-1:0] u_max,
   input  logic         clear,
   input  logic         hold,
   output logic [N-1:0] u,
   output logic         u_valid,
   output logic         busy,
   output logic         sat_hi,
   output logic         sat_lo,
   output logic         overrun
);

   localparam int ACCW = N + aN + 2;

   state_e state_q, state_d;

   logic                   start;
   logic                   m_busy_unused;
   logic                   m_done;
   logic [2*N-1:0]         m_prod;

   logic [N-1:0]           acc_q, acc_d;
   logic                   u_valid_q;
   logic                   sat_hi_q, sat_hi_d;
   logic                   sat_lo_q, sat_lo_d;
   logic                   overrun_q;

   logic signed [2*N-1:0]  prod_sh;
   logic signed [ACCW-1:0] sum;
   logic signed [ACCW-1:0] umin_x;
   logic signed [ACCW-1:0] umax_x;
   logic                   unused_prod;

   serial_mult_signed #(.N(N)) u_mult (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .a       (du),
      .b       (k_gain),
      .busy    (m_busy_unused),
      .done    (m_done),
      .product (m_prod)
   );

   assign unused_prod = ^prod_sh[2*N-1:ACCW];

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // next state; clear wins over any incoming sample
   always_comb begin
      state_d = state_q;
      start   = 1'b0;
      if (clear) begin
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (du_valid) begin
                  start   = 1'b1;
                  state_d = S_MUL;
               end
            end
            S_MUL:   if (m_done) state_d = S_ACC;
            S_ACC:   state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // scale, add and clamp the new accumulator value
   always_comb begin
      prod_sh  = $signed(m_prod) >>> (N - aN);
      umin_x   = {{(ACCW-N){u_min[N-1]}}, u_min};
      umax_x   = {{(ACCW-N){u_max[N-1]}}, u_max};
      sum      = $signed({{(ACCW-N){acc_q[N-1]}}, acc_q})
               + prod_sh[ACCW-1:0];
      acc_d    = acc_q;
      sat_hi_d = sat_hi_q;
      sat_lo_d = sat_lo_q;
      if (state_q == S_ACC && !hold) begin
         sat_hi_d = 1'b0;
         sat_lo_d = 1'b0;
         if (sum > umax_x) begin
            acc_d    = u_max;
            sat_hi_d = 1'b1;
         end else if (sum < umin_x) begin
            acc_d    = u_min;
            sat_lo_d = 1'b1;
         end else begin
            acc_d = sum[N-1:0];
         end
      end
   end

   // accumulator, flags and output strobe
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q     <= '0;
         u_valid_q <= 1'b0;
         sat_hi_q  <= 1'b0;
         sat_lo_q  <= 1'b0;
         overrun_q <= 1'b0;
      end else if (clear) begin
         acc_q     <= '0;
         u_valid_q <= 1'b0;
         sat_hi_q  <= 1'b0;
         sat_lo_q  <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         acc_q     <= acc_d;
         sat_hi_q  <= sat_hi_d;
         sat_lo_q  <= sat_lo_d;
         u_valid_q <= (state_q == S_ACC);
         if (du_valid && state_q != S_IDLE) overrun_q <= 1'b1;
      end
   end

   assign u       = acc_q;
   assign u_valid = u_valid_q;
   assign busy    = (state_q != S_IDLE);
   assign sat_hi  = sat_hi_q;
   assign sat_lo  = sat_lo_q;
   assign overrun = overrun_q;

endmodule

// File: tb/tb_fuzzy_pi_integrator.sv
// Directed bench for fuzzy_pi_integrator (N=16, aN=4,
// limits 0x9000..0x7000).
module tb_fuzzy_pi_integrator;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        du_valid = 1'b0;
   logic [15:0] du = '0;
   logic [15:0] k_gain = '0;
   logic [15:0] u_min = 16'h9000;
   logic [15:0] u_max = 16'h7000;
   logic        clear = 1'b0;
   logic        hold = 1'b0;
   logic [15:0] u;
   logic        u_valid;
   logic        busy;
   logic        sat_hi;
   logic        sat_lo;
   logic        overrun;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] du;
      logic [15:0] k;
      logic        hold;
      logic [15:0] exp_u;
      logic        exp_hi;
      logic        exp_lo;
   } vec_t;

   vec_t vecs [14];

   fuzzy_pi_integrator dut (
      .clk      (clk),
      .rst      (rst),
      .du_valid (du_valid),
      .du       (du),
      .k_gain   (k_gain),
      .u_min    (u_min),
      .u_max    (u_max),
      .clear    (clear),
      .hold     (hold),
      .u        (u),
      .u_valid  (u_valid),
      .busy     (busy),
      .sat_hi   (sat_hi),
      .sat_lo   (sat_lo),
      .overrun  (overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_op(input logic [15:0] d, input logic [15:0] k,
                         input logic h);
      int lat;
      lat = 0;
      @(negedge clk);
      du = d; k_gain = k; hold = h; du_valid = 1'b1;
      @(posedge clk);
      #1 du_valid = 1'b0;
      chk("busy_after_accept", 32'(busy), 32'd1);
      while (!u_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("latency", 32'(lat), 32'd18);
      chk("busy_at_uvalid", 32'(busy), 32'd0);
   endtask

   task automatic count_uvalid(input int cycles, output int n);
      n = 0;
      for (int c = 0; c < cycles; c++) begin
         @(posedge clk);
         #1;
         if (u_valid) n++;
      end
   endtask

   task automatic run_rows(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         run_op(vecs[i].du, vecs[i].k, vecs[i].hold);
         chk($sformatf("row%0d_u", i), 32'(u), 32'(vecs[i].exp_u));
         chk($sformatf("row%0d_hi", i), 32'(sat_hi),
             32'(vecs[i].exp_hi));
         chk($sformatf("row%0d_lo", i), 32'(sat_lo),
             32'(vecs[i].exp_lo));
      end
   endtask

   initial begin
      int n;
      int lat;
      vecs[0]  = '{16'h4000, 16'h1000, 1'b0, 16'h4000, 1'b0, 1'b0};
      vecs[1]  = '{16'h4000, 16'h1000, 1'b0, 16'h7000, 1'b1, 1'b0};
      vecs[2]  = '{16'hC000, 16'h1000, 1'b1, 16'h7000, 1'b1, 1'b0};
      vecs[3]  = '{16'hC000, 16'h1000, 1'b0, 16'h3000, 1'b0, 1'b0};
      vecs[4]  = '{16'h0001, 16'h0800, 1'b0, 16'h3000, 1'b0, 1'b0};
      vecs[5]  = '{16'h0001, 16'hF800, 1'b0, 16'h2FFF, 1'b0, 1'b0};
      vecs[6]  = '{16'h8000, 16'h1000, 1'b0, 16'hAFFF, 1'b0, 1'b0};
      vecs[7]  = '{16'hC000, 16'h2000, 1'b0, 16'h9000, 1'b0, 1'b1};
      vecs[8]  = '{16'hC000, 16'h2000, 1'b0, 16'h9000, 1'b0, 1'b1};
      vecs[9]  = '{16'h4000, 16'h2000, 1'b0, 16'h1000, 1'b0, 1'b0};
      vecs[10] = '{16'h7FFF, 16'h7FFF, 1'b0, 16'h7000, 1'b1, 1'b0};
      vecs[11] = '{16'h8000, 16'h8000, 1'b0, 16'h7000, 1'b1, 1'b0};
      vecs[12] = '{16'h7FFF, 16'h8000, 1'b0, 16'h9000, 1'b0, 1'b1};
      vecs[13] = '{16'h4000, 16'h1000, 1'b0, 16'h4000, 1'b0, 1'b0};

      repeat (3) @(posedge clk);
      #1;
      chk("rst_u", 32'(u), 32'h0);
      chk("rst_uvalid", 32'(u_valid), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_flags", 32'({sat_hi, sat_lo, overrun}), 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // back-to-back rows also exercise accept-during-u_valid
      run_rows(0, 6);
      chk("no_overrun_b2b", 32'(overrun), 32'h0);

      // second sample 5 cycles into an operation is dropped
      @(negedge clk);
      du = 16'h4000; k_gain = 16'h1000; hold = 1'b0; du_valid = 1'b1;
      @(posedge clk);
      #1 du_valid = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      du = 16'h7FFF; du_valid = 1'b1;
      @(posedge clk);
      #1 du_valid = 1'b0;
      chk("overrun_set", 32'(overrun), 32'h1);
      lat = 0;
      while (!u_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("overrun_uvalid_seen", 32'(u_valid), 32'h1);
      chk("overrun_u", 32'(u), 32'hEFFF);
      count_uvalid(25, n);
      chk("overrun_single_uvalid", 32'(n), 32'h0);

      // clear beats a simultaneous sample
      @(negedge clk);
      clear = 1'b1; du = 16'h4000; du_valid = 1'b1;
      @(posedge clk);
      #1 clear = 1'b0; du_valid = 1'b0;
      chk("clear_u", 32'(u), 32'h0);
      chk("clear_overrun", 32'(overrun), 32'h0);
      chk("clear_busy", 32'(busy), 32'h0);
      count_uvalid(25, n);
      chk("clear_no_uvalid", 32'(n), 32'h0);

      run_rows(7, 12);

      // asynchronous reset in the middle of the multiply
      @(negedge clk);
      du = 16'h4000; k_gain = 16'h1000; du_valid = 1'b1;
      @(posedge clk);
      #1 du_valid = 1'b0;
      repeat (8) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("midrst_u", 32'(u), 32'h0);
      chk("midrst_outs",
          32'({u_valid, busy, sat_hi, sat_lo, overrun}), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      count_uvalid(20, n);
      chk("midrst_no_uvalid", 32'(n), 32'h0);

      run_rows(13, 13);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
